ccff_loader: RTL and testbench
==============================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 12, giving the number of configuration flip-flops in the target ccff chain.
REQ-002 The block SHALL have parameter WORD_W, default 8, giving the bitstream word width in bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, named as follows.
- prog_clk  in  1  programming clock.
- prog_reset  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have these further ports.
- start_load  in  1  one-cycle request to load the chain.
- start_readback  in  1  one-cycle request for non-destructive readback.
- cfg_data  in  WORD_W  bitstream word.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  loader accepts a word.
- rd_data  out  WORD_W  readback word.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- ccff_head  out  1  serial data into the chain head.
- ccff_tail  in  1  serial data from the chain tail.
- ccff_shift_en  out  1  chain shifts on a prog_clk rising edge where this is 1 (clock gating is external).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-005 The FSM SHALL have states IDLE, LD_WAIT, LD_SHIFT, RB_SHIFT, RB_OUT and FIN.
REQ-006 In IDLE, start_load SHALL transition to LD_WAIT; start_readback SHALL transition to RB_SHIFT; if both are high in the same cycle, load SHALL win.
REQ-007 Start requests SHALL be ignored in every state except IDLE.
REQ-008 cfg_ready SHALL be 1 only in LD_WAIT; a word is accepted on the edge where cfg_valid and cfg_ready are both 1, and the FSM then moves to LD_SHIFT.
REQ-009 In LD_SHIFT, ccff_shift_en SHALL be 1 every cycle for k = min(WORD_W, bits remaining) cycles.
REQ-010 In LD_SHIFT, ccff_head SHALL present the word MSB first, one bit per cycle; bits of a final partial word beyond k SHALL be discarded.
REQ-011 After the k shifts, the FSM SHALL go to LD_WAIT if bits remain, otherwise to FIN.
REQ-012 A single remaining-bit counter of width clog2(CHAIN_LEN+1) SHALL be loaded with CHAIN_LEN on start and SHALL decrement once per asserted ccff_shift_en; it SHALL never underflow.
REQ-013 The first bit shifted SHALL end in the chain-tail flip-flop, so the bitstream is ordered tail-first.
REQ-014 In RB_SHIFT, ccff_head SHALL equal ccff_tail combinationally (recirculation), and ccff_shift_en SHALL be 1.
REQ-015 In RB_SHIFT, ccff_tail SHALL be sampled at each shifting edge into the capture register, first bit at the MSB.
REQ-016 After WORD_W bits, or when the remaining-bit counter reaches 0, the FSM SHALL go to RB_OUT with rd_valid=1.
REQ-017 A partial final readback word SHALL be left-aligned and zero-padded.
REQ-018 In RB_OUT, rd_data SHALL stay stable and ccff_shift_en SHALL be 0 until rd_ready=1.
REQ-019 On the RB_OUT handshake edge, the FSM SHALL go to RB_SHIFT if bits remain, otherwise to FIN.
REQ-020 After exactly CHAIN_LEN readback shifts, the chain contents SHALL equal their pre-readback values.
REQ-021 ccff_shift_en SHALL be 0 in IDLE, LD_WAIT, RB_OUT and FIN; ccff_head SHALL be 0 in these states.
REQ-022 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-023 Total chain shifts per operation SHALL be exactly CHAIN_LEN.
REQ-024 Load latency with cfg_valid held high SHALL be CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles from start_load to done.

Reset
REQ-025 While prog_reset=1, the block SHALL be asynchronously forced to IDLE with all of the following at 0: cfg_ready, rd_valid, rd_data, ccff_head, ccff_shift_en, busy, done, and all counters.
REQ-026 Reset asserted mid-operation SHALL stop shifting immediately and SHALL NOT produce done; the chain contents are then undefined, and a new load after reset release SHALL complete normally.

Verification
REQ-027 Load check (CHAIN_LEN=12, WORD_W=8): load words 0xA5, 0x3C -> ccff_head serial sequence 1,0,1,0,0,1,0,1,0,0,1,1; 12 shift-enable cycles; one done pulse; behavioral chain model holds that sequence with the first bit at the tail.
REQ-028 Readback check: readback after REQ-027 -> rd_data 0xA5 then 0x30; chain model unchanged afterward; done asserted once.
REQ-029 Readback backpressure: hold rd_ready=0 for 5 cycles in RB_OUT -> ccff_shift_en stays 0 and rd_data stays stable; completion is delayed by exactly 5 cycles.
REQ-030 Load input gaps: drop cfg_valid for 3 cycles between words -> no shifting during the gap; final chain content identical to REQ-027.
REQ-031 Reset mid-load: assert prog_reset after 5 shifts -> all outputs 0 in the same cycle and no done; a subsequent full load passes REQ-027.
REQ-032 Start arbitration: assert start_load and start_readback together -> load performed; pulse start_readback while busy -> ignored, and the operation count is unchanged.

Source files
------------

// File: rtl/ccff_loader_if.sv
// Handshake and chain-side signals between the ccff loader and its bitstream
// source, readback consumer and configuration chain.
interface ccff_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic              start_load;
    logic              start_readback;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_shift_en;
    logic              busy;
    logic              done;

    modport slave (
        input  start_load, start_readback, cfg_data, cfg_valid, rd_ready, ccff_tail,
        output cfg_ready, rd_data, rd_valid, ccff_head, ccff_shift_en, busy, done
    );

    modport master (
        output start_load, start_readback, cfg_data, cfg_valid, rd_ready, ccff_tail,
        input  cfg_ready, rd_data, rd_valid, ccff_head, ccff_shift_en, busy, done
    );
endinterface

// File: rtl/ccff_loader.sv
// Serial loader / non-destructive readback engine for a configuration
// flip-flop chain; bitstream is word-based, ordered tail-first, MSB-first.
module ccff_loader #(
    parameter int unsigned CHAIN_LEN = 12,
    parameter int unsigned WORD_W    = 8
) (
    input  logic         prog_clk,
    input  logic         prog_reset,
    ccff_loader_if.slave bus
);
    localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned BW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT,
        LD_SHIFT,
        RB_SHIFT,
        RB_OUT,
        FIN
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     rem_q, rem_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] cap_q, cap_d;
    logic              last_word;
    logic              last_chain;

    assign bus.rd_data = cap_q;

    // Next-state, counters and chain-side outputs
    always_comb begin
        state_d           = state_q;
        rem_d             = rem_q;
        bit_d             = bit_q;
        word_d            = word_q;
        cap_d             = cap_q;
        bus.cfg_ready     = 1'b0;
        bus.rd_valid      = 1'b0;
        bus.ccff_head     = 1'b0;
        bus.ccff_shift_en = 1'b0;
        bus.done          = 1'b0;
        bus.busy          = (state_q != IDLE);
        last_word         = (bit_q == BW'(WORD_W - 1));
        last_chain        = (rem_q <= CW'(1));

        case (state_q)
            IDLE: begin
                if (bus.start_load) begin
                    state_d = LD_WAIT;
                    rem_d   = CW'(CHAIN_LEN);
                end else if (bus.start_readback) begin
                    state_d = RB_SHIFT;
                    rem_d   = CW'(CHAIN_LEN);
                    bit_d   = '0;
                    cap_d   = '0;
                end
            end
            LD_WAIT: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid) begin
                    word_d  = bus.cfg_data;
                    bit_d   = '0;
                    state_d = LD_SHIFT;
                end
            end
            LD_SHIFT: begin
                bus.ccff_shift_en = 1'b1;
                bus.ccff_head     = word_q[WORD_W-1];
                word_d            = word_q << 1;
                bit_d             = bit_q + BW'(1);
                if (rem_q != '0) rem_d = rem_q - CW'(1);
                // Leftover bits of a partial final word are simply dropped
                if (last_chain)     state_d = FIN;
                else if (last_word) state_d = LD_WAIT;
            end
            RB_SHIFT: begin
                bus.ccff_shift_en = 1'b1;
                bus.ccff_head     = bus.ccff_tail;
                cap_d             = cap_q | (WORD_W'(bus.ccff_tail) << (BW'(WORD_W - 1) - bit_q));
                bit_d             = bit_q + BW'(1);
                if (rem_q != '0) rem_d = rem_q - CW'(1);
                if (last_chain || last_word) state_d = RB_OUT;
            end
            RB_OUT: begin
                bus.rd_valid = 1'b1;
                if (bus.rd_ready) begin
                    if (rem_q == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = RB_SHIFT;
                        bit_d   = '0;
                        cap_d   = '0;
                    end
                end
            end
            FIN: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            cap_q   <= cap_d;
        end
    end
endmodule

// File: tb/tb_ccff_loader.sv
// Directed and randomized checks of ccff_loader against a queue-based model
// of the tail-first bitstream and a behavioural target chain.
module tb_ccff_loader;
    localparam int unsigned CHAIN_LEN = 12;
    localparam int unsigned WORD_W    = 8;
    localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int          BASE_LAT  = CHAIN_LEN + NWORDS + 1;
    localparam int          TMO       = 200;

    logic prog_clk = 1'b0;
    logic prog_reset;

    ccff_loader_if #(.WORD_W(WORD_W)) bus ();

    ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .bus        (bus)
    );

    always #5 prog_clk = ~prog_clk;

    // Target chain: index CHAIN_LEN-1 is the tail flop
    logic [CHAIN_LEN-1:0] chain = '0;
    assign bus.ccff_tail = chain[CHAIN_LEN-1];

    int cyc     = 0;
    int n_shift = 0;
    int n_done  = 0;
    bit head_log[$];

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (bus.ccff_shift_en) begin
            chain   <= {chain[CHAIN_LEN-2:0], bus.ccff_head};
            n_shift <= n_shift + 1;
            head_log.push_back(bus.ccff_head);
        end
        if (bus.done) n_done <= n_done + 1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Reference model: chain contents as the list of bits, tail first
    bit exp_bits[$];
    logic [WORD_W-1:0] words[$];
    logic [WORD_W-1:0] rd_got[$];

    function automatic void model_load(input logic [WORD_W-1:0] ws[$]);
        exp_bits.delete();
        foreach (ws[i])
            for (int b = WORD_W - 1; b >= 0; b--)
                if (exp_bits.size() < CHAIN_LEN) exp_bits.push_back(ws[i][b]);
    endfunction

    function automatic logic [31:0] pack_bits(input bit q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    function automatic logic [31:0] model_rd_word(input int w);
        logic [31:0] v = '0;
        for (int b = 0; b < WORD_W; b++)
            if (w * WORD_W + b < CHAIN_LEN) v = v | (32'(exp_bits[w * WORD_W + b]) << (WORD_W - 1 - b));
        return v;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_outs"}, 32'({bus.cfg_ready, bus.rd_valid, bus.ccff_head,
                                   bus.ccff_shift_en, bus.busy, bus.done}), 32'd0);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
    endtask

    task automatic wait_done(input int start_cyc, output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int c = 0; c < TMO && !seen; c++) begin
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc - start_cyc;
            end else begin
                tick();
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) tick();
    endtask

    task automatic do_load(input logic [WORD_W-1:0] ws[$], input int gap, input bit with_rb,
                           input bit poke, output int lat);
        int start_cyc;
        int sh;
        bit rdy;
        bit ok;
        head_log.delete();
        bus.start_load     = 1'b1;
        bus.start_readback = with_rb;
        start_cyc          = cyc;
        tick();
        bus.start_load     = 1'b0;
        bus.start_readback = 1'b0;
        foreach (ws[i]) begin
            if (i > 0 && gap > 0) begin
                for (int c = 0; c < TMO && !bus.cfg_ready; c++) tick();
                sh = n_shift;
                repeat (gap) begin
                    check("gap_shift_en", 32'(bus.ccff_shift_en), 32'd0);
                    tick();
                end
                check("gap_no_shift", 32'(n_shift - sh), 32'd0);
            end
            bus.cfg_data  = ws[i];
            bus.cfg_valid = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < TMO && !ok; c++) begin
                rdy = bus.cfg_ready;
                tick();
                ok = rdy;
            end
            bus.cfg_valid = 1'b0;
            check("cfg_accept", 32'(ok), 32'd1);
            if (poke && i == 0) begin
                bus.start_readback = 1'b1;
                tick();
                bus.start_readback = 1'b0;
            end
        end
        wait_done(start_cyc, lat);
    endtask

    task automatic do_readback(input int stall_word, input int stall, input bit poke, output int lat);
        int start_cyc;
        logic [WORD_W-1:0] hold;
        head_log.delete();
        rd_got.delete();
        bus.start_readback = 1'b1;
        start_cyc          = cyc;
        tick();
        bus.start_readback = 1'b0;
        for (int w = 0; w < NWORDS; w++) begin
            for (int c = 0; c < TMO && !bus.rd_valid; c++) tick();
            check("rd_valid_seen", 32'(bus.rd_valid), 32'd1);
            check("rd_word", 32'(bus.rd_data), model_rd_word(w));
            rd_got.push_back(bus.rd_data);
            if (w == stall_word) begin
                repeat (stall) begin
                    hold = bus.rd_data;
                    tick();
                    check("bp_shift_en", 32'(bus.ccff_shift_en), 32'd0);
                    check("bp_rd_stable", 32'(bus.rd_data), 32'(hold));
                end
            end
            bus.start_load = poke;
            bus.rd_ready   = 1'b1;
            tick();
            bus.rd_ready   = 1'b0;
            bus.start_load = 1'b0;
        end
        wait_done(start_cyc, lat);
    endtask

    initial begin
        int lat;
        int s0;
        int d0;
        int gap;
        int stall;
        int sw;

        bus.start_load     = 1'b0;
        bus.start_readback = 1'b0;
        bus.cfg_data       = '0;
        bus.cfg_valid      = 1'b0;
        bus.rd_ready       = 1'b0;
        prog_reset         = 1'b1;
        repeat (2) @(posedge prog_clk);
        #1;
        check_quiet("reset");
        prog_reset = 1'b0;
        tick();

        // Reference load; both starts together, load must win
        words = '{8'hA5, 8'h3C};
        model_load(words);
        s0 = n_shift; d0 = n_done;
        do_load(words, 0, 1'b1, 1'b1, lat);
        check("ld_head_seq", pack_bits(head_log), 32'hA53);
        check("ld_shifts", 32'(n_shift - s0), 32'(CHAIN_LEN));
        check("ld_done_cnt", 32'(n_done - d0), 32'd1);
        check("ld_latency", 32'(lat), 32'(BASE_LAT));
        check("ld_chain", 32'(chain), pack_bits(exp_bits));
        repeat (3) tick();
        check("ld_idle_busy", 32'(bus.busy), 32'd0);
        check("ld_idle_done_cnt", 32'(n_done - d0), 32'd1);

        // Readback with start_load poked while busy
        s0 = n_shift; d0 = n_done;
        do_readback(-1, 0, 1'b1, lat);
        check("rb_word0", 32'(rd_got[0]), 32'hA5);
        check("rb_word1", 32'(rd_got[1]), 32'h30);
        check("rb_recirc", pack_bits(head_log), pack_bits(exp_bits));
        check("rb_chain", 32'(chain), 32'hA53);
        check("rb_shifts", 32'(n_shift - s0), 32'(CHAIN_LEN));
        check("rb_latency", 32'(lat), 32'(BASE_LAT));
        repeat (3) tick();
        check("rb_busy", 32'(bus.busy), 32'd0);
        check("rb_done_cnt", 32'(n_done - d0), 32'd1);

        // Readback backpressure on the first word
        do_readback(0, 5, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'(BASE_LAT + 5));
        check("bp_chain", 32'(chain), 32'hA53);

        // Different content, then reference load with a 3-cycle input gap
        words = '{8'h5A, 8'hC3};
        model_load(words);
        do_load(words, 0, 1'b0, 1'b0, lat);
        check("alt_chain", 32'(chain), pack_bits(exp_bits));
        words = '{8'hA5, 8'h3C};
        model_load(words);
        s0 = n_shift; d0 = n_done;
        do_load(words, 3, 1'b0, 1'b0, lat);
        check("gap_chain", 32'(chain), 32'hA53);
        check("gap_shifts", 32'(n_shift - s0), 32'(CHAIN_LEN));
        check("gap_latency", 32'(lat), 32'(BASE_LAT + 3));
        check("gap_done_cnt", 32'(n_done - d0), 32'd1);

        // Reset after five load shifts
        s0 = n_shift; d0 = n_done;
        bus.start_load = 1'b1;
        tick();
        bus.start_load = 1'b0;
        bus.cfg_data   = 8'hFF;
        bus.cfg_valid  = 1'b1;
        for (int c = 0; c < TMO && (n_shift - s0) < 5; c++) tick();
        check("rst_after5", 32'(n_shift - s0), 32'd5);
        prog_reset    = 1'b1;
        bus.cfg_valid = 1'b0;
        #1;
        check_quiet("midrst");
        repeat (3) tick();
        check("midrst_no_shift", 32'(n_shift - s0), 32'd5);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        prog_reset = 1'b0;
        tick();
        s0 = n_shift; d0 = n_done;
        do_load(words, 0, 1'b0, 1'b0, lat);
        check("post_rst_head_seq", pack_bits(head_log), 32'hA53);
        check("post_rst_chain", 32'(chain), 32'hA53);
        check("post_rst_done_cnt", 32'(n_done - d0), 32'd1);
        check("post_rst_latency", 32'(lat), 32'(BASE_LAT));

        // Randomized load / readback rounds
        for (int r = 0; r < 6; r++) begin
            words.delete();
            for (int i = 0; i < NWORDS; i++) words.push_back(WORD_W'($urandom));
            model_load(words);
            gap   = int'($urandom_range(0, 3));
            stall = int'($urandom_range(0, 4));
            sw    = int'($urandom_range(0, NWORDS - 1));
            s0 = n_shift;
            do_load(words, gap, 1'b0, 1'b0, lat);
            check("rnd_ld_chain", 32'(chain), pack_bits(exp_bits));
            check("rnd_ld_seq", pack_bits(head_log), pack_bits(exp_bits));
            check("rnd_ld_latency", 32'(lat), 32'(BASE_LAT + gap * (NWORDS - 1)));
            do_readback(sw, stall, 1'b0, lat);
            check("rnd_rb_chain", 32'(chain), pack_bits(exp_bits));
            check("rnd_rb_latency", 32'(lat), 32'(BASE_LAT + stall));
            check("rnd_shifts", 32'(n_shift - s0), 32'(2 * CHAIN_LEN));
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
